uart_tx_sender: RTL

Transmit side of the board's host serial link. Buffers bytes produced by on-board logic in a small FIFO. When the send switch is asserted, it drains the FIFO onto the UART TX line as 8N1 frames, LSB first. It mirrors the receive/echo path, which feeds it bytes and displays the count and last-sent byte on LEDs and 7-segment displays.

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_byte_fifo.sv | 62 ++++++
 rtl/uart_tx_sender.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the host-link UART transmit path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;
  localparam logic [7:0]  LF                   = 8'h0A;
  localparam logic        UART_IDLE            = 1'b1;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with registered full/empty flags and a
// combinational head-of-queue view for the transmitter to load from.
module sync_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic [7:0] wr_data,
  input  logic       rd,
  output logic [7:0] head_c,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          push_c;
  logic          pop_c;

  // A simultaneous pop frees the slot, so a push while full is accepted then.
  assign pop_c  = rd && !empty;
  assign push_c = wr && (!full || pop_c);
  assign head_c = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push_c, pop_c})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == CW'(0));
    end
  end

  // Storage carries no reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_sender.sv
// Host-link UART transmitter: drains a byte FIFO as 8N1 frames while i_Send is high.
// Optional UART_TX_EOL_EN appends one LF frame each time a send drains the FIFO.
module uart_tx_sender
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic [7:0]       i_Data,
  input  logic             i_Wr,
  input  logic             i_Send,
  output logic             o_Full,
  output logic             o_Empty,
  output logic             o_Busy,
  output logic             o_UART_TXD,
  output logic [7:0]       o_Last_Tx,
  output logic [CNT_W-1:0] o_Count
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_t         state, state_nxt;
  logic [BAUD_W-1:0] baud, baud_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [7:0]        shift, shift_nxt;
  logic [7:0]        tx_byte, tx_byte_nxt;
  logic              txd_nxt;
  logic              busy_nxt;
  logic [7:0]        last_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              pop_c;
  logic              load_c;
  logic [7:0]        load_byte_c;
  logic [7:0]        head_c;
  logic              baud_end_c;
`ifdef UART_TX_EOL_EN
  logic              lf_frame, lf_frame_nxt;
`endif

  sync_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (i_Clk),
    .rst_n   (i_Rst_n),
    .wr      (i_Wr),
    .wr_data (i_Data),
    .rd      (pop_c),
    .head_c  (head_c),
    .full    (o_Full),
    .empty   (o_Empty)
  );

  assign baud_end_c = (baud == BAUD_W'(CLKS_PER_BIT - 1));

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    tx_byte_nxt = tx_byte;
    txd_nxt     = o_UART_TXD;
    busy_nxt    = o_Busy;
    last_nxt    = o_Last_Tx;
    count_nxt   = o_Count;
    pop_c       = 1'b0;
    load_c      = 1'b0;
    load_byte_c = head_c;
`ifdef UART_TX_EOL_EN
    lf_frame_nxt = lf_frame;
`endif

    if (state != IDLE) baud_nxt = baud_end_c ? '0 : baud + BAUD_W'(1);

    case (state)
      IDLE: begin
        txd_nxt  = UART_IDLE;
        busy_nxt = 1'b0;
        if (i_Send && !o_Empty) begin
          pop_c  = 1'b1;
          load_c = 1'b1;
`ifdef UART_TX_EOL_EN
          lf_frame_nxt = 1'b0;
`endif
        end
      end
      START: begin
        txd_nxt = 1'b0;
        if (baud_end_c) begin
          state_nxt   = DATA;
          bit_idx_nxt = 3'd0;
          txd_nxt     = shift[0];
        end
      end
      DATA: begin
        if (baud_end_c) begin
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            txd_nxt   = UART_IDLE;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            txd_nxt     = shift[1];
          end
        end
      end
      STOP: begin
        txd_nxt = UART_IDLE;
        if (baud_end_c) begin
          last_nxt = tx_byte;
          if (o_Count != '1) count_nxt = o_Count + CNT_W'(1);
          if (i_Send && !o_Empty) begin
            pop_c  = 1'b1;
            load_c = 1'b1;
`ifdef UART_TX_EOL_EN
            lf_frame_nxt = 1'b0;
          end else if (i_Send && !lf_frame) begin
            // FIFO just ran dry behind a real byte: close the drain with one LF.
            load_c       = 1'b1;
            load_byte_c  = LF;
            lf_frame_nxt = 1'b1;
`endif
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        txd_nxt   = UART_IDLE;
        busy_nxt  = 1'b0;
      end
    endcase

    // Frame launch: start bit appears on the line from the next edge.
    if (load_c) begin
      state_nxt   = START;
      baud_nxt    = '0;
      shift_nxt   = load_byte_c;
      tx_byte_nxt = load_byte_c;
      txd_nxt     = 1'b0;
      busy_nxt    = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state      <= IDLE;
      baud       <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      tx_byte    <= '0;
      o_UART_TXD <= UART_IDLE;
      o_Busy     <= 1'b0;
      o_Last_Tx  <= '0;
      o_Count    <= '0;
`ifdef UART_TX_EOL_EN
      lf_frame   <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      baud       <= baud_nxt;
      bit_idx    <= bit_idx_nxt;
      shift      <= shift_nxt;
      tx_byte    <= tx_byte_nxt;
      o_UART_TXD <= txd_nxt;
      o_Busy     <= busy_nxt;
      o_Last_Tx  <= last_nxt;
      o_Count    <= count_nxt;
`ifdef UART_TX_EOL_EN
      lf_frame   <= lf_frame_nxt;
`endif
    end
  end

endmodule
